// File: rtl/lzc_pkg.sv
// Shared widths and helpers for the leading-zero counter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lzc_pkg;

  // Widths the FPU normalization path instantiates, with their log widths.
  localparam int LZC_XLEN_4   = 4;
  localparam int LZC_XLEN_8   = 8;
  localparam int LZC_XLEN_16  = 16;
  localparam int LZC_XLEN_32  = 32;
  localparam int LZC_XLEN_64  = 64;
  localparam int LZC_XLEN_128 = 128;

  localparam int LZC_XLOG_4   = 2;
  localparam int LZC_XLOG_8   = 3;
  localparam int LZC_XLOG_16  = 4;
  localparam int LZC_XLOG_32  = 5;
  localparam int LZC_XLOG_64  = 6;
  localparam int LZC_XLOG_128 = 7;

  localparam int LZC_XLEN_MIN = LZC_XLEN_4;
  localparam int LZC_XLEN_MAX = LZC_XLEN_128;

  // Ceiling log2, usable in constant expressions for parameter checks.
  function automatic int lzc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit lzc_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// One tree node: combines the upper (left) and lower (right) half results.
// Latency: combinational.
// Backpressure: none.
//   vl/cl : valid flag and index from the upper half (W bits)
//   vr/cr : valid flag and index from the lower half (W bits)
//   v/c   : merged valid flag and index (W+1 bits)
module lzc_merge
  import lzc_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         vl,
  input  logic [W-1:0] cl,
  input  logic         vr,
  input  logic [W-1:0] cr,
  output logic         v,
  output logic [W:0]   c
);

  // The upper half wins whenever it holds any set bit, so its valid flag
  // doubles as the new index MSB.
  assign v = vl | vr;
  assign c = {vl, (vl ? cl : cr)};

endmodule

// File: rtl/leading_zero_counter.sv
// Leading-one detector: registered index of the highest set bit of a (~c = leading zeros).
// Latency: 1 cycle, new operand accepted every cycle.
// Backpressure: none; no handshake.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   a     : operand to scan (XLEN bits)
//   c     : index of highest set bit (XLOG bits), 0 when a == 0
//   v     : 1 when a has any set bit
module leading_zero_counter
  import lzc_pkg::*;
#(
  parameter int XLEN = 128,
  parameter int XLOG = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  output logic [XLOG-1:0] c,
  output logic            v
);

  if (!lzc_is_pow2(XLEN) || (XLEN < LZC_XLEN_MIN) || (XLEN > LZC_XLEN_MAX) ||
      (XLOG != lzc_clog2(XLEN))) begin : g_bad_param
    $error("leading_zero_counter: XLEN must be a power of two in 4..128 and XLOG = log2(XLEN)");
  end

  // Level l holds XLEN >> (l+1) nodes, each with an (l+1)-bit index.
  for (genvar l = 0; l < XLOG; l++) begin : g_lvl
    localparam int N = XLEN >> (l + 1);
    logic [N-1:0] nv;
    logic [l:0]   nc [N];

    if (l == 0) begin : g_leaf
      // 2-bit group: index bit is simply the upper bit of the pair.
      for (genvar j = 0; j < N; j++) begin : g_node
        assign nv[j] = a[2*j+1] | a[2*j];
        assign nc[j] = a[2*j+1];
      end
    end else begin : g_tree
      for (genvar j = 0; j < N; j++) begin : g_node
        lzc_merge #(.W(l)) u_merge (
          .vl (g_lvl[l-1].nv[2*j+1]),
          .cl (g_lvl[l-1].nc[2*j+1]),
          .vr (g_lvl[l-1].nv[2*j]),
          .cr (g_lvl[l-1].nc[2*j]),
          .v  (nv[j]),
          .c  (nc[j])
        );
      end
    end
  end

  logic            tree_v;
  logic [XLOG-1:0] tree_c;

  // With a == 0 every mux falls through to the leaf bit, so tree_c is 0.
  assign tree_v = g_lvl[XLOG-1].nv[0];
  assign tree_c = g_lvl[XLOG-1].nc[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c <= '0;
      v <= 1'b0;
    end else begin
      c <= tree_c;
      v <= tree_v;
    end
  end

endmodule

// File: tb/tb_leading_zero_counter.sv
module tb_leading_zero_counter;

  logic         clock;
  logic         reset;
  logic [15:0]  a16;
  logic [31:0]  a32;
  logic [127:0] a128;
  logic [3:0]   c16;
  logic [4:0]   c32;
  logic [6:0]   c128;
  logic         v16, v32, v128;

  int n_checks = 0;
  int n_pass   = 0;

  leading_zero_counter #(.XLEN(16), .XLOG(4)) u_dut16 (
    .clock (clock), .reset (reset), .a (a16), .c (c16), .v (v16)
  );
  leading_zero_counter #(.XLEN(32), .XLOG(5)) u_dut32 (
    .clock (clock), .reset (reset), .a (a32), .c (c32), .v (v32)
  );
  leading_zero_counter #(.XLEN(128), .XLOG(7)) u_dut128 (
    .clock (clock), .reset (reset), .a (a128), .c (c128), .v (v128)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: scan from the top for the first 1; -1 when none.
  function automatic int hsb(input logic [127:0] x, input int w);
    for (int i = w - 1; i >= 0; i--)
      if (x[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic check_w(input string tag, input int w, input logic [127:0] x,
                         input logic [6:0] c, input logic v);
    int idx;
    idx = hsb(x, w);
    check($sformatf("%s_w%0d_v", tag, w), {127'd0, v}, (idx >= 0) ? 128'd1 : 128'd0);
    check($sformatf("%s_w%0d_c", tag, w), {121'd0, c}, (idx >= 0) ? 128'(idx) : 128'd0);
  endtask

  task automatic check_all(input string tag);
    check_w(tag, 16,  {112'd0, a16}, {3'd0, c16}, v16);
    check_w(tag, 32,  {96'd0, a32},  {2'd0, c32}, v32);
    check_w(tag, 128, a128,          c128,        v128);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rnd_operand();
    logic [127:0] x;
    int mode;
    mode = $urandom_range(0, 4);
    case (mode)
      0: x = '0;
      1: begin x = 128'd1; x = x << $urandom_range(0, 127); end
      2: begin
        x = '0;
        for (int k = 0; k < 3; k++) begin
          logic [127:0] b;
          b = 128'd1;
          x = x | (b << $urandom_range(0, 127));
        end
      end
      3: begin
        x = {$urandom, $urandom, $urandom, $urandom};
        x = x >> $urandom_range(0, 127);
      end
      default: x = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return x;
  endfunction

  initial begin
    logic [127:0] one;
    logic [127:0] r;
    one   = 128'd1;
    reset = 1'b0;
    a16   = 16'h1;
    a32   = 32'h1;
    a128  = 128'h1;

    // Held in reset with a nonzero operand: outputs stay clear.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_v128", {127'd0, v128}, 128'd0);
      check("rst_c128", {121'd0, c128}, 128'd0);
      check("rst_v16",  {127'd0, v16},  128'd0);
    end

    @(negedge clock);
    reset = 1'b1;

    // First edge after release captures the current operand.
    tick();
    check_all("post_rst");

    // Walking one across all widths.
    for (int k = 0; k < 128; k++) begin
      a128 = one << k;
      a32  = 32'(one << (k % 32));
      a16  = 16'(one << (k % 16));
      tick();
      check_all("walk");
      check("walk_lz128", {121'd0, ~c128}, 128'(127 - k));
    end

    // Zero then MSB-only.
    a128 = '0; a32 = '0; a16 = '0;
    tick();
    check_all("zero");
    check("zero_c128", {121'd0, c128}, 128'd0);
    a128 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    a32  = 32'h8000_0000;
    a16  = 16'h8000;
    tick();
    check("msb_c128", {121'd0, c128}, 128'h7f);
    check("msb_lz128", {121'd0, ~c128}, 128'd0);
    check_all("msb");

    // Bits below the leading one are ignored.
    a32 = 32'h0001_FFFF; a128 = 128'h0001_FFFF; a16 = 16'h0FFF;
    tick();
    check("mask_c32", {123'd0, c32}, 128'd16);
    check_all("mask");
    a32 = 32'hFFFF_FFFF; a128 = '1; a16 = 16'hFFFF;
    tick();
    check("ones_c32", {123'd0, c32}, 128'd31);
    check("ones_c128", {121'd0, c128}, 128'd127);
    check_all("ones");

    // Back-to-back 16-bit sequence.
    a16 = 16'h0001; tick(); check("b2b0_c", {124'd0, c16}, 128'd0);  check("b2b0_v", {127'd0, v16}, 128'd1);
    a16 = 16'h0080; tick(); check("b2b1_c", {124'd0, c16}, 128'd7);  check("b2b1_v", {127'd0, v16}, 128'd1);
    a16 = 16'h8000; tick(); check("b2b2_c", {124'd0, c16}, 128'd15); check("b2b2_v", {127'd0, v16}, 128'd1);
    a16 = 16'h0000; tick(); check("b2b3_c", {124'd0, c16}, 128'd0);  check("b2b3_v", {127'd0, v16}, 128'd0);

    // Asynchronous reset mid-run: clears with no clock edge.
    a128 = '1; a32 = '1; a16 = '1;
    tick();
    check_all("pre_async");
    #2;
    reset = 1'b0;
    #1;
    check("async_v128", {127'd0, v128}, 128'd0);
    check("async_c128", {121'd0, c128}, 128'd0);
    check("async_c32",  {123'd0, c32},  128'd0);
    check("async_c16",  {124'd0, c16},  128'd0);
    @(negedge clock);
    reset = 1'b1;

    // Randomized operands, all widths in parallel.
    for (int i = 0; i < 10000; i++) begin
      r    = rnd_operand();
      a128 = r;
      r    = rnd_operand();
      a32  = r[31:0];
      r    = rnd_operand();
      a16  = ($urandom_range(0, 1) == 1) ? r[127:112] : r[15:0];
      tick();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
